// File: rtl/qam_mapper_if.sv
// Bit-stream in / constellation-point out bundle for the QAM mapper.
// The upstream interleaver drives the master side; the mapper is the slave.
interface qam_mapper_if #(
    parameter int OUT_W = 8
);
    logic                    iEN;
    logic                    iRateEN;
    logic [3:0]              iRate;
    logic                    iData;
    logic signed [OUT_W-1:0] oI;
    logic signed [OUT_W-1:0] oQ;
    logic                    oValid;
    logic [5:0]              oSC;
    logic                    oLast;

    modport master (
        output iEN, iRateEN, iRate, iData,
        input  oI, oQ, oValid, oSC, oLast
    );

    modport slave (
        input  iEN, iRateEN, iRate, iData,
        output oI, oQ, oValid, oSC, oLast
    );
endinterface

// File: rtl/qam_mapper.sv
// 802.11a constellation mapper (BPSK / QPSK / 16-QAM).
// Serial interleaved bits are gathered LSB-first into a group of Nbpsc bits;
// the completed group is mapped to a signed I/Q pair one cycle later and
// tagged with its data-subcarrier index 0..47.
module qam_mapper #(
    parameter int OUT_W = 8
) (
    input logic         iClk,
    input logic         iRst,
    qam_mapper_if.slave bus
);

    typedef enum logic [1:0] {
        MOD_BPSK,
        MOD_QPSK,
        MOD_QAM16
    } mod_t;

    logic [3:0]              rate;
    logic [1:0]              bit_cnt;
    logic [3:0]              group;
    logic [5:0]              sc_cnt;

    mod_t                    mod;
    logic [1:0]              last_idx;
    logic [3:0]              full_group;
    logic                    group_done;
    logic                    emit;
    logic signed [7:0]       i_lvl;
    logic signed [7:0]       q_lvl;

    logic signed [OUT_W-1:0] i_reg;
    logic signed [OUT_W-1:0] q_reg;
    logic                    valid_reg;
    logic [5:0]              sc_reg;

    // Gray-coded 16-QAM axis level; 'first' is the earlier-received bit.
    function automatic logic signed [7:0] gray_level(input logic first, input logic second);
        logic signed [7:0] lvl;
        case ({first, second})
            2'b00:   lvl = -8'sd61;
            2'b01:   lvl = -8'sd20;
            2'b11:   lvl =  8'sd20;
            default: lvl =  8'sd61;
        endcase
        return lvl;
    endfunction

    // Decode the RATE register into a modulation and the index of a group's last bit.
    always_comb begin
        mod      = MOD_BPSK;
        last_idx = 2'd0;
        case (rate)
            4'b0101, 4'b0111: begin
                mod      = MOD_QPSK;
                last_idx = 2'd1;
            end
            4'b1001, 4'b1011: begin
                mod      = MOD_QAM16;
                last_idx = 2'd3;
            end
            default: begin
                mod      = MOD_BPSK;
                last_idx = 2'd0;
            end
        endcase
    end

    // Merge the incoming bit into the group so a completing bit can be mapped in the same cycle.
    always_comb begin
        full_group          = group;
        full_group[bit_cnt] = bus.iData;
        group_done          = (bit_cnt == last_idx);
        emit                = !bus.iRateEN && bus.iEN && group_done;
    end

    // Map the completed group to I/Q levels at the fixed 8-bit scale.
    always_comb begin
        i_lvl = 8'sd0;
        q_lvl = 8'sd0;
        case (mod)
            MOD_QPSK: begin
                i_lvl = full_group[0] ? 8'sd45 : -8'sd45;
                q_lvl = full_group[1] ? 8'sd45 : -8'sd45;
            end
            MOD_QAM16: begin
                i_lvl = gray_level(full_group[0], full_group[1]);
                q_lvl = gray_level(full_group[2], full_group[3]);
            end
            default: begin
                i_lvl = full_group[0] ? 8'sd64 : -8'sd64;
                q_lvl = 8'sd0;
            end
        endcase
    end

    // RATE, bit collection and subcarrier counting; a rate load discards any partial group.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rate    <= 4'b1101;
            bit_cnt <= 2'd0;
            group   <= 4'd0;
            sc_cnt  <= 6'd0;
        end else if (bus.iRateEN) begin
            rate    <= bus.iRate;
            bit_cnt <= 2'd0;
            group   <= 4'd0;
            sc_cnt  <= 6'd0;
        end else if (bus.iEN) begin
            if (group_done) begin
                bit_cnt <= 2'd0;
                group   <= 4'd0;
                sc_cnt  <= (sc_cnt == 6'd47) ? 6'd0 : sc_cnt + 6'd1;
            end else begin
                bit_cnt <= bit_cnt + 2'd1;
                group   <= full_group;
            end
        end
    end

    // Output register: a one-cycle valid strobe, with I/Q/index held between strobes.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            i_reg     <= '0;
            q_reg     <= '0;
            sc_reg    <= 6'd0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= emit;
            if (emit) begin
                i_reg  <= OUT_W'(i_lvl);
                q_reg  <= OUT_W'(q_lvl);
                sc_reg <= sc_cnt;
            end
        end
    end

    assign bus.oI     = i_reg;
    assign bus.oQ     = q_reg;
    assign bus.oSC    = sc_reg;
    assign bus.oValid = valid_reg;
    assign bus.oLast  = valid_reg && (sc_reg == 6'd47);

endmodule

// File: doc/qam_mapper.md
QAM_MAPPER -- requirements
Module: qam_mapper

Interface
REQ-001 The block SHALL have parameter OUT_W, default 8, meaning the signed two's-complement width of oI and oQ.
REQ-002 The block SHALL have port iClk, input, 1, system clock (fast); all state SHALL update on its rising edge.
REQ-003 The block SHALL have port iRst, input, 1, reset, asynchronous, active-high.
REQ-004 The block SHALL have port iEN, input, 1, input bit strobe, driven by the upstream interleaver oValid.
REQ-005 The block SHALL have port iRateEN, input, 1, RATE load enable.
REQ-006 The block SHALL have port iRate, input, 4, 802.11a RATE code.
REQ-007 The block SHALL have port iData, input, 1, serial interleaved bit, sampled when iEN=1.
REQ-008 The block SHALL have port oI, output, OUT_W, in-phase value, signed.
REQ-009 The block SHALL have port oQ, output, OUT_W, quadrature value, signed.
REQ-010 The block SHALL have port oValid, output, 1, one-cycle strobe marking a new oI/oQ pair.
REQ-011 The block SHALL have port oSC, output, 6, data-subcarrier index 0..47 of the current oI/oQ pair.
REQ-012 The block SHALL have port oLast, output, 1, asserted with oValid when oSC=47.

Function
REQ-013 RATE SHALL be a 4-bit register loaded from iRate when iRateEN=1; modulation and Nbpsc SHALL follow RATE.
REQ-014 RATE 1101/1111 SHALL select BPSK (Nbpsc=1).
REQ-015 RATE 0101/0111 SHALL select QPSK (Nbpsc=2).
REQ-016 RATE 1001/1011 SHALL select 16-QAM (Nbpsc=4).
REQ-017 All other RATE codes (including 0001, 0011) SHALL be treated as BPSK; 64-QAM is out of scope.
REQ-018 Bits SHALL be collected LSB-first into a 4-bit group register; b0 is the first bit received.
REQ-019 A bit counter (0..Nbpsc-1) SHALL increment on each iEN=1 cycle and wrap to 0 after the Nbpsc-th bit.
REQ-020 On the iEN cycle carrying the last bit of a group, mapped values SHALL be registered: oValid=1 on the next cycle (1-cycle latency) for exactly one cycle.
REQ-021 BPSK mapping SHALL be: b0=0 -> I=-64, b0=1 -> I=+64; Q=0.
REQ-022 QPSK mapping SHALL be: b0 gives I (0 -> -45, 1 -> +45); b1 gives Q (0 -> -45, 1 -> +45).
REQ-023 16-QAM mapping SHALL be Gray-coded, b0b1 giving I and b2b3 giving Q: 00 -> -61, 01 -> -20, 11 -> +20, 10 -> +61.
REQ-024 The constants in REQ-021 to REQ-023 SHALL be fixed values for OUT_W=8; for wider OUT_W they SHALL be sign-extended, not rescaled.
REQ-025 oI, oQ and oSC SHALL hold their last values between oValid pulses.
REQ-026 The subcarrier counter SHALL increment after each emitted pair and wrap 47 -> 0; oSC SHALL show the index of the pair being presented.
REQ-027 oLast SHALL equal oValid AND (oSC==47).
REQ-028 iEN=0 cycles SHALL freeze the bit counter, the group register and the subcarrier counter (gaps are allowed mid-group).
REQ-029 When iRateEN=1, the block SHALL clear the bit counter, the group register and the subcarrier counter; oValid SHALL be 0 on the next cycle.
REQ-030 When iRateEN and iEN are both 1, iRateEN SHALL win: the bit SHALL be discarded and the new RATE SHALL apply from the next iEN.
REQ-031 A partial group pending at iRateEN SHALL be dropped silently with no output.

Reset
REQ-032 On iRst=1, RATE SHALL be 1101 (BPSK), the counters and group register SHALL be 0, oI=oQ=0, oSC=0, oValid=0, oLast=0, all immediately and without waiting for iClk.
REQ-033 Reset asserted mid-group or mid-symbol SHALL abandon all pending bits; after release the first iEN bit SHALL be treated as b0 of subcarrier 0.

Verification
REQ-034 BPSK (after reset): bits 1,0 with iEN=1 -> oValid pulses (I=+64,Q=0,oSC=0) then (I=-64,Q=0,oSC=1), each 1 cycle after its bit.
REQ-035 QPSK: bits 1,0 -> one pulse, I=+45, Q=-45, oSC=0; no pulse after the first bit.
REQ-036 16-QAM: bits 1,0,0,1 with iEN gaps between bits -> one pulse, I=+61, Q=-20.
REQ-037 BPSK: 48 consecutive bits -> 48 pulses with oSC 0..47, oLast only on the 48th; the 49th bit -> oSC=0.
REQ-038 16-QAM: two bits, then iRateEN with QPSK code, then bits 0,1 -> exactly one pulse, I=-45, Q=+45, oSC=0.
REQ-039 Async reset mid-symbol (oSC=20): all outputs 0 immediately; the next QPSK-length input after reconfiguration maps from oSC=0.
